psum_accumulator: RTL and testbench

- Accumulates partial sums (psums) arriving one per clock from a PE column into groups of NUM_PSUM consecutive inputs.
- At the end of each group, it registers the group total on accum_out and then restarts from zero.
- Sits between the PE array output and the output buffer/activation stage.
- There is no input handshake: every clock after reset release consumes one psum.

---
 rtl/psum_accumulator.sv | 78 +++++++
 tb/tb_psum_accumulator.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sums NUM_PSUM consecutive unsigned partial sums from a PE column into one
// group total, registers it on accum_out with a one-cycle out_valid pulse,
// then restarts from zero on the very next edge (no bubble between groups).
//
// Build option:
//   PSUM_ACC_SAT_EN  - when defined, a group total that does not fit in
//                      DATA_W bits clamps to all ones instead of wrapping.
module psum_accumulator #(
    parameter int DATA_W   = 16,
    parameter int NUM_PSUM = 3,
    parameter int ACC_W    = DATA_W + $clog2(NUM_PSUM) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           psum_in,
    output logic [DATA_W-1:0]           accum_out,
    output logic                        out_valid,
    output logic [$clog2(NUM_PSUM):0]   psum_cnt
);

    localparam int CNT_W = $clog2(NUM_PSUM) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PSUM - 1);

    // Reduce a full-width group total to the output width.
    function automatic logic [DATA_W-1:0] fold_total(input logic [ACC_W-1:0] s);
`ifdef PSUM_ACC_SAT_EN
        if (|s[ACC_W-1:DATA_W]) begin
            return {DATA_W{1'b1}};
        end
        return DATA_W'(s);
`else
        return DATA_W'(s);
`endif
    endfunction

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] accum_q, accum_d;
    logic              vld_q, vld_d;
    logic [ACC_W-1:0]  sum;

    // Next-state: keep absorbing psums until the last slot of the group,
    // which publishes the total and restarts the running sum at zero.
    always_comb begin
        sum     = acc_q + ACC_W'(psum_in);
        acc_d   = sum;
        cnt_d   = cnt_q + CNT_W'(1);
        accum_d = accum_q;
        vld_d   = 1'b0;
        if (cnt_q == LAST_CNT) begin
            acc_d   = '0;
            cnt_d   = '0;
            accum_d = fold_total(sum);
            vld_d   = 1'b1;
        end
    end

    // State registers; synchronous active-low reset drops any partial group.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            accum_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            accum_q <= accum_d;
            vld_q   <= vld_d;
        end
    end

    assign accum_out = accum_q;
    assign out_valid = vld_q;
    assign psum_cnt  = cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a NUM_PSUM=3 instance checked against
// a scoreboard of group totals, plus a NUM_PSUM=1 instance.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] psum_in;
    logic [15:0] psum1_in;

    logic [15:0] acc3, acc1;
    logic        vld3, vld1;
    logic [2:0]  cnt3;
    logic [0:0]  cnt1;

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_q[$];
    logic [31:0] m_acc;
    int          m_cnt;
    logic [15:0] m_last;
    logic        m_vld;

    always #5 clk = ~clk;

    psum_accumulator #(.DATA_W(16), .NUM_PSUM(3)) dut3 (
        .clk(clk), .rst(rst), .psum_in(psum_in),
        .accum_out(acc3), .out_valid(vld3), .psum_cnt(cnt3)
    );

    psum_accumulator #(.DATA_W(16), .NUM_PSUM(1)) dut1 (
        .clk(clk), .rst(rst), .psum_in(psum1_in),
        .accum_out(acc1), .out_valid(vld1), .psum_cnt(cnt1)
    );

    function automatic logic [15:0] fold(input logic [31:0] x);
`ifdef PSUM_ACC_SAT_EN
        return (x > 32'h0000_FFFF) ? 16'hFFFF : x[15:0];
`else
        return x[15:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one edge, update the model, then check the NUM_PSUM=3 outputs.
    task automatic step(input logic r, input logic [15:0] d);
        rst     = r;
        psum_in = d;
        if (!r) begin
            m_acc = 0; m_cnt = 0; m_last = 16'h0; m_vld = 1'b0;
            exp_q.delete();
        end else begin
            m_acc = m_acc + 32'(d);
            m_cnt++;
            m_vld = 1'b0;
            if (m_cnt == 3) begin
                exp_q.push_back(fold(m_acc));
                m_acc = 0; m_cnt = 0; m_vld = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(vld3), 32'(m_vld));
        chk("psum_cnt", 32'(cnt3), 32'(m_cnt));
        if (vld3) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) m_last = exp_q.pop_front();
            chk("accum_out", 32'(acc3), 32'(m_last));
        end else begin
            chk("accum_hold", 32'(acc3), 32'(m_last));
        end
    endtask

    initial begin
        rst = 1'b0; psum_in = 16'h0; psum1_in = 16'h0;
        m_acc = 0; m_cnt = 0; m_last = 16'h0; m_vld = 1'b0;
        #1;

        // Reset
        step(1'b0, 16'd0);
        chk("rst_accum", 32'(acc3), 32'd0);
        chk("rst_n1_valid", 32'(vld1), 32'd0);
        chk("rst_n1_accum", 32'(acc1), 32'd0);

        // First group 10,20,30
        step(1'b1, 16'd10);
        step(1'b1, 16'd20);
        chk("pre_grp1_valid", 32'(vld3), 32'd0);
        step(1'b1, 16'd30);
        chk("grp1_total", 32'(acc3), 32'd60);
        chk("grp1_valid", 32'(vld3), 32'd1);

        // Back-to-back group 5,15,25
        step(1'b1, 16'd5);
        chk("grp2_hold", 32'(acc3), 32'd60);
        chk("grp2_pulse_end", 32'(vld3), 32'd0);
        step(1'b1, 16'd15);
        step(1'b1, 16'd25);
        chk("grp2_total", 32'(acc3), 32'd45);

        // Reset mid-group discards 10+20
        step(1'b1, 16'd10);
        step(1'b1, 16'd20);
        step(1'b0, 16'd99);
        chk("midrst_accum", 32'(acc3), 32'd0);
        chk("midrst_cnt", 32'(cnt3), 32'd0);
        step(1'b1, 16'd1);
        step(1'b1, 16'd2);
        step(1'b1, 16'd3);
        chk("grp3_total", 32'(acc3), 32'd6);

        // Overflow
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'h0002);
        step(1'b1, 16'h0000);
`ifdef PSUM_ACC_SAT_EN
        chk("ovf_total", 32'(acc3), 32'h0000_FFFF);
`else
        chk("ovf_total", 32'(acc3), 32'h0000_0001);
`endif
        chk("ovf_valid", 32'(vld3), 32'd1);

        // Large group sum that fits exactly at the top of the range
        step(1'b1, 16'hFFF0);
        step(1'b1, 16'h000E);
        step(1'b1, 16'h0001);
        chk("top_total", 32'(acc3), 32'h0000_FFFF);

        // NUM_PSUM=1 instance: every edge completes a group
        psum1_in = 16'd7;
        step(1'b1, 16'd0);
        chk("n1_first", 32'(acc1), 32'd7);
        chk("n1_valid_a", 32'(vld1), 32'd1);
        chk("n1_cnt", 32'(cnt1), 32'd0);
        psum1_in = 16'd9;
        step(1'b1, 16'd0);
        chk("n1_second", 32'(acc1), 32'd9);
        chk("n1_valid_b", 32'(vld1), 32'd1);
        psum1_in = 16'hFFFF;
        step(1'b1, 16'd0);
        chk("n1_max", 32'(acc1), 32'h0000_FFFF);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
